// File: rtl/ifu_prefetch_if.sv
// Instruction-bus bundle between ifu_prefetch (master) and the memory side (slave).
// Also provides fallback values for the core-wide defines when no global header is present.
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h0000_0080
`endif
`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_IF
`define STALL_IF 1
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

interface ifu_prefetch_if;
   logic        instr_req_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_addr_o;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;

   modport master (
      output instr_req_o,
      output instr_addr_o,
      input  instr_gnt_i,
      input  instr_rvalid_i,
      input  instr_rdata_i,
      input  instr_err_i
   );

   modport slave (
      input  instr_req_o,
      input  instr_addr_o,
      output instr_gnt_i,
      output instr_rvalid_i,
      output instr_rdata_i,
      output instr_err_i
   );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch FIFO and flush-time response discard.
// Optional feature IFU_PREFETCH_ERR_EN: store bus errors per entry and halt fetch after one.
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h0000_0080
`endif
`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_IF
`define STALL_IF 1
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_prefetch #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_ADDR = `CPU_RESET_ADDR
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic [31:0]             flush_addr_i,
   input  logic [`STALL_WIDTH-1:0] stall_i,
   input  logic                    id_ready_i,
   output logic [31:0]             inst_o,
   output logic [31:0]             pc_o,
   output logic                    inst_valid_o,
   output logic                    inst_err_o,
   ifu_prefetch_if.master          bus
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   typedef enum logic [0:0] {
      StReset,
      StRun
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] out_pc_q, out_pc_d;
   cnt_t        outstanding_q, outstanding_d;
   cnt_t        discard_q, discard_d;
   cnt_t        count_q, count_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;

   logic [31:0] data_mem [FIFO_DEPTH];

   logic        fetch_hold;
   logic [CW:0] inflight;
   logic        credit_ok;
   logic        req;
   logic        grant;
   logic        rsp_dec;
   logic        push;
   logic        pop;
   logic [31:0] flush_tgt;

`ifdef IFU_PREFETCH_ERR_EN
   logic        err_mem [FIFO_DEPTH];
   logic        halt_q, halt_d;
   logic        unused_inputs;

   assign fetch_hold    = halt_q;
   assign unused_inputs = ^stall_i;
`else
   logic        unused_inputs;

   assign fetch_hold    = 1'b0;
   assign unused_inputs = ^{stall_i, bus.instr_err_i};
`endif

   // Credit covers both buffered entries and in-flight requests, so a response always has room.
   assign inflight  = {1'b0, outstanding_q} + {1'b0, count_q};
   assign credit_ok = inflight < (CW + 1)'(FIFO_DEPTH);

   assign req       = (state_q == StRun) & ~stall_i[`STALL_IF] & ~flush_i & credit_ok & ~fetch_hold;
   assign grant     = req & bus.instr_gnt_i;
   assign rsp_dec   = bus.instr_rvalid_i & (outstanding_q != '0);
   assign push      = bus.instr_rvalid_i & (discard_q == '0) & ~flush_i;
   assign pop       = inst_valid_o & id_ready_i;
   assign flush_tgt = flush_addr_i & ~32'd3;

   always_comb begin
      state_d       = state_q;
      fetch_addr_d  = fetch_addr_q;
      out_pc_d      = out_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
`ifdef IFU_PREFETCH_ERR_EN
      halt_d        = halt_q;
`endif

      unique case (state_q)
         StReset: state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StReset;
      endcase

      if (grant && !rsp_dec) begin
         outstanding_d = outstanding_q + 1'b1;
      end else if (!grant && rsp_dec) begin
         outstanding_d = outstanding_q - 1'b1;
      end

      if (bus.instr_rvalid_i && discard_q != '0) begin
         discard_d = discard_q - 1'b1;
      end

      if (grant) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         out_pc_d = out_pc_q + 32'd4;
      end

`ifdef IFU_PREFETCH_ERR_EN
      if (push && bus.instr_err_i) begin
         halt_d = 1'b1;
      end
`endif

      // Everything still in flight at the flush is stale; a response landing now is already gone.
      if (flush_i) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         fetch_addr_d = flush_tgt;
         out_pc_d     = flush_tgt;
         discard_d    = outstanding_q - cnt_t'(rsp_dec);
`ifdef IFU_PREFETCH_ERR_EN
         halt_d       = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StReset;
         fetch_addr_q  <= RESET_ADDR;
         out_pc_q      <= RESET_ADDR;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         out_pc_q      <= out_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

`ifdef IFU_PREFETCH_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= bus.instr_rdata_i;
`ifdef IFU_PREFETCH_ERR_EN
         err_mem[wr_ptr_q]  <= bus.instr_err_i;
`endif
      end
   end

   assign bus.instr_req_o  = req;
   assign bus.instr_addr_o = fetch_addr_q;
   assign inst_valid_o     = (count_q != '0) & ~flush_i;
   assign inst_o           = inst_valid_o ? data_mem[rd_ptr_q] : `INST_NOP;
   assign pc_o             = out_pc_q;
`ifdef IFU_PREFETCH_ERR_EN
   assign inst_err_o       = inst_valid_o & err_mem[rd_ptr_q];
`else
   assign inst_err_o       = 1'b0;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (count_q < cnt_t'(FIFO_DEPTH)) || pop);
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      bus.instr_rvalid_i |-> outstanding_q != '0);
   a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req && !bus.instr_gnt_i) |=> bus.instr_addr_o == $past(bus.instr_addr_o));

endmodule
